systolic_fir_tdm: RTL
=====================

Name: systolic_fir_tdm

Overview:
- Parametrised successor to the fixed 8-tap 16-bit systolic filter wrapper.
- Time-division-multiplexed FIR: one sample frame spans (timing+1) fast clocks, and one shared pipelined MAC walks TAPS coefficients per frame.
- Adds a double-buffered coefficient bank, round-half-up scaling with saturation, a frame-tick output and a timing-error flag.
- Sits between the sample source and the downstream filter stage, clocked by the oversampled clock.

Parameters:
DW, 16, signed data width of xin/yout
CW, 16, signed coefficient width
TAPS, 8, number of filter taps (>=2)
FRAC, 14, fractional bits of coefficients (right-shift applied to accumulator)
ACCW, 40, accumulator width (>= DW+CW+clog2(TAPS))
TW, 32, width of timing input

Ports:
clk30x  in  1  oversampled clock
rst  in  1  reset, asynchronous, active-low
timing  in  TW  clocks per sample frame minus 1 (e.g. 29)
xin  in  DW  signed input sample, sampled at frame start
coef_we  in  1  shadow coefficient write strobe
coef_addr  in  clog2(TAPS)  shadow coefficient index
coef_data  in  CW  signed coefficient value
coef_commit  in  1  request shadow->active copy at next frame start
sat_clr  in  1  clears sat_flag
yout  out  DW  signed filtered output, held between updates
yout_valid  out  1  one-cycle pulse when yout updates
frame_tick  out  1  one-cycle pulse at cnt==0
sat_flag  out  1  sticky saturation indicator
timing_err  out  1  frame too short for computation

Behaviour:
- Reset (rst=0, async): cnt=0, timing_q=0, delay line, active and shadow coefficients, acc, yout=0; yout_valid, frame_tick, sat_flag, timing_err=0; pending commit cleared.
- Frame counter cnt: increments each clk30x; wraps to 0 when cnt==timing_q. timing_q is loaded from timing only at the wrap (cnt==timing_q) and on the first cycle after reset release. A mid-frame change of timing therefore takes effect at the next frame.
- At cnt==0:
  - frame_tick=1.
  - xin is shifted into delay line x[0]; x[k] moves to x[k+1]; x[TAPS-1] is dropped.
  - If a commit is pending, all TAPS active coefficients are loaded from the shadow bank in this cycle, before the MAC uses them, and the pending flag clears.
  - acc=0.
  - timing_err is evaluated as (timing_q < TAPS+2) and held for the whole frame.
- MAC (timing_err=0):
  - Cycles cnt=1..TAPS issue product p=x[cnt-1]*c[cnt-1] into a registered multiplier (full CW+DW signed).
  - Cycles cnt=2..TAPS+1 add the sign-extended registered product into acc.
  - At cnt==TAPS+2: r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic), saturated to signed DW range. yout=r and yout_valid=1 for exactly this cycle.
  - Saturation sets sat_flag. sat_flag holds until sat_clr=1. If sat_clr and a new saturation occur in the same cycle, the set wins.
- timing_err=1: no MAC, yout holds, yout_valid stays 0. The delay line still shifts and commits still apply.
- Coefficient writes: coef_we writes shadow[coef_addr] in the same cycle, at any time. Active coefficients never change mid-frame. coef_commit is latched as pending. A coef_we in the cycle of a cnt==0 copy lands in shadow after the copy and is not included.
- A coef_commit pulse coinciding with cnt==0 is applied at the following frame start.
- Latency: xin captured at frame start appears in yout TAPS+2 clocks later (same frame), contributing through tap 0.
- Frame-start cycle ordering: shift, then commit, then acc clear; no combinational path from xin to yout.

Test Plan:
- Identity: commit c0=0x4000, others 0, timing=29; xin=0x1234 at frame k -> yout=0x1234, yout_valid pulse at cnt==10 of frame k, once per frame.
- Delay tap: c3=0x4000, others 0; impulse 0x0100 in frame k then zeros -> yout=0x0100 only in frame k+3, 0x0000 in all other frames.
- Rounding: c0=0x2000. xin=0x0003 -> yout=0x0002. xin=0xFFFD -> yout=0xFFFF. xin=0x0001 -> yout=0x0001.
- Saturation: all c=0x7FFF, xin=0x7FFF for 8 frames -> yout=0x7FFF and sat_flag=1. xin=0x8000 -> yout=0x8000. sat_clr pulse with benign data -> sat_flag=0.
- Commit timing: write shadow mid-frame without commit -> output unchanged. Pulse coef_commit at cnt==15 -> new coefficients are used from the next frame only. A write at that frame's cnt==0 is not copied.
- Timing error/reset:
  - timing=5 (TAPS=8) -> timing_err=1, no yout_valid, yout held.
  - Restore timing=29 -> valid output resumes from the following frame.
  - Deassert-then-assert rst mid-MAC -> all outputs 0 immediately, cnt restarts at 0.

Source files
------------

// File: rtl/systolic_fir_tdm_if.sv
// systolic_fir_tdm_if: sample, coefficient-bank and status signals of the TDM FIR.
interface systolic_fir_tdm_if #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int TAPS = 8,
  parameter int TW = 32
);
  logic [TW-1:0] timing;
  logic signed [DW-1:0] xin;
  logic coef_we;
  logic [$clog2(TAPS)-1:0] coef_addr;
  logic signed [CW-1:0] coef_data;
  logic coef_commit;
  logic sat_clr;
  logic signed [DW-1:0] yout;
  logic yout_valid;
  logic frame_tick;
  logic sat_flag;
  logic timing_err;
  modport master (
    output timing, xin, coef_we, coef_addr, coef_data, coef_commit, sat_clr,
    input  yout, yout_valid, frame_tick, sat_flag, timing_err
  );
  modport slave (
    input  timing, xin, coef_we, coef_addr, coef_data, coef_commit, sat_clr,
    output yout, yout_valid, frame_tick, sat_flag, timing_err
  );
endinterface

// File: rtl/systolic_fir_tdm.sv
// systolic_fir_tdm: time-multiplexed FIR, one pipelined MAC walks all taps once per sample frame,
// with double-buffered coefficients, round-half-up scaling, saturation and a frame-length check.
module systolic_fir_tdm #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int TAPS = 8,
  parameter int FRAC = 14,
  parameter int ACCW = 40,
  parameter int TW = 32
) (
  input logic clk30x,
  input logic rst,
  systolic_fir_tdm_if.slave bus
);
  localparam int AW = $clog2(TAPS);
  localparam int PW = DW + CW;
  localparam logic signed [ACCW-1:0] RND = {{(ACCW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

  logic [TW-1:0] cnt_q, cnt_d, timing_q;
  logic signed [DW-1:0] x_q [TAPS];
  logic signed [CW-1:0] c_q [TAPS];
  logic signed [CW-1:0] shadow_q [TAPS];
  logic signed [PW-1:0] p_q;
  logic signed [ACCW-1:0] acc_q, acc_d, sum, sh;
  logic [AW-1:0] idx;
  logic signed [DW-1:0] yout_q;
  logic yout_valid_q, frame_tick_q, sat_flag_q, timing_err_q, pending_q;
  logic wrap, start, issue, mac_add, fire, hi, lo;

  // The frame-length check is registered at the wrap from the value being loaded into
  // timing_q, so it is already valid during the cnt==0 cycle of the frame it describes.
  always_comb begin
    wrap = cnt_q == timing_q;
    start = cnt_q == '0;
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    issue = !timing_err_q && cnt_q >= TW'(1) && cnt_q <= TW'(TAPS);
    mac_add = !timing_err_q && cnt_q >= TW'(2) && cnt_q <= TW'(TAPS + 1);
    fire = !timing_err_q && cnt_q == TW'(TAPS + 1);
    idx = AW'(cnt_q - 1'b1);
    acc_d = start ? '0 : mac_add ? acc_q + {{(ACCW-PW){p_q[PW-1]}}, p_q} : acc_q;
    sum = acc_d + RND;
    sh = sum >>> FRAC;
    hi = sh > YMAX;
    lo = sh < YMIN;
  end

  always_ff @(posedge clk30x or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      timing_q <= '0;
      x_q <= '{default: '0};
      c_q <= '{default: '0};
      shadow_q <= '{default: '0};
      p_q <= '0;
      acc_q <= '0;
      yout_q <= '0;
      yout_valid_q <= 1'b0;
      frame_tick_q <= 1'b0;
      sat_flag_q <= 1'b0;
      timing_err_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (wrap) begin
        timing_q <= bus.timing;
        timing_err_q <= bus.timing < TW'(TAPS + 2);
      end
      frame_tick_q <= wrap;
      if (start) begin
        x_q[0] <= bus.xin;
        for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
        if (pending_q) c_q <= shadow_q;
      end
      pending_q <= (pending_q && !start) || bus.coef_commit;
      if (bus.coef_we) shadow_q[bus.coef_addr] <= bus.coef_data;
      if (issue) p_q <= x_q[idx] * c_q[idx];
      acc_q <= acc_d;
      yout_valid_q <= fire;
      if (fire) yout_q <= hi ? YMAX[DW-1:0] : lo ? YMIN[DW-1:0] : sh[DW-1:0];
      sat_flag_q <= (fire && (hi || lo)) || (sat_flag_q && !bus.sat_clr);
    end
  end

  assign bus.yout = yout_q;
  assign bus.yout_valid = yout_valid_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.sat_flag = sat_flag_q;
  assign bus.timing_err = timing_err_q;
endmodule
